// File: rtl/mux_sel_arbiter_pkg.sv
// Shared types and constants for the two-source mux select arbiter.
// State encoding is fixed so that downstream debug taps can decode it.
package mux_sel_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  localparam logic SEL_SRC0 = 1'b0;
  localparam logic SEL_SRC1 = 1'b1;

  // Grant state for a source index.
  function automatic state_t grant_state(input logic idx);
    return idx ? G1 : G0;
  endfunction

  // Mux select value for a source index.
  function automatic logic sel_for(input logic idx);
    return idx ? SEL_SRC1 : SEL_SRC0;
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_hold_timer.sv
// Saturating hold counter for the current mux owner.
// expired flags the last permitted contended cycle; never asserts when MAX_HOLD is 0.
module hold_timer #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // With MAX_HOLD=0 the limit collapses to 0, which also holds the count at 0.
  localparam logic [CNT_W-1:0] LIMIT = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic             HOLD_ON = (MAX_HOLD != 0);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  always_comb begin
    expired = HOLD_ON && (count == LIMIT);
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Two-source round-robin arbiter driving a registered 2:1 mux select.
// Every owner change passes through IDLE, giving one dead cycle between owners.
module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic sel,
  output logic valid
);

  state_t state;
  state_t next_state;
  logic   last;
  logic   expired;
  logic   win_idx;
  logic   entering;

  hold_timer #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) u_hold_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == IDLE),
    .enable  (state != IDLE),
    .expired (expired)
  );

  always_comb begin
    next_state = state;
    win_idx    = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the source that did not win last time goes next.
        if (req0 && req1) begin
          win_idx    = ~last;
          next_state = grant_state(~last);
        end else if (req0) begin
          win_idx    = 1'b0;
          next_state = G0;
        end else if (req1) begin
          win_idx    = 1'b1;
          next_state = G1;
        end
      end
      G0: begin
        if (!req0 || (expired && req1)) begin
          next_state = IDLE;
        end
      end
      G1: begin
        if (!req1 || (expired && req0)) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    entering = (state == IDLE) && (next_state != IDLE);
  end

  // Outputs are decoded from next_state into flops so they align with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      sel   <= SEL_SRC0;
      valid <= 1'b0;
    end else begin
      state <= next_state;
      gnt0  <= (next_state == G0);
      gnt1  <= (next_state == G1);
      valid <= (next_state != IDLE);
      if (entering) begin
        sel  <= sel_for(win_idx);
        last <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter: three instances cover MAX_HOLD of 16, 4 and 0.
module tb_mux_sel_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_req0 = 1'b0, a_req1 = 1'b0;
  logic b_req0 = 1'b0, b_req1 = 1'b0;
  logic c_req0 = 1'b0, c_req1 = 1'b0;
  logic a_gnt0, a_gnt1, a_sel, a_valid;
  logic b_gnt0, b_gnt1, b_sel, b_valid;
  logic c_gnt0, c_gnt1, c_sel, c_valid;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  mux_sel_arbiter #(.MAX_HOLD(16), .CNT_W(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .req0(a_req0), .req1(a_req1),
    .gnt0(a_gnt0), .gnt1(a_gnt1), .sel(a_sel), .valid(a_valid));

  mux_sel_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req0(b_req0), .req1(b_req1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .sel(b_sel), .valid(b_valid));

  mux_sel_arbiter #(.MAX_HOLD(0), .CNT_W(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .req0(c_req0), .req1(c_req1),
    .gnt0(c_gnt0), .gnt1(c_gnt1), .sel(c_sel), .valid(c_valid));

  // Output nibble ordering: {gnt0, gnt1, sel, valid}
  typedef struct packed {
    logic       r0;
    logic       r1;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {gnt0,gnt1,sel,valid}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_excl(input string name, input logic g0, input logic g1);
    n_checks++;
    if (g0 && g1) begin
      n_fail++;
      $display("FAIL %s: both grants high at %0t", name, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_b;
    logic       prev_valid;
    logic       prev_sel;
    int unsigned p;

    vecs[0]  = '{1'b1, 1'b0, 4'b1001};
    vecs[1]  = '{1'b1, 1'b0, 4'b1001};
    vecs[2]  = '{1'b1, 1'b1, 4'b1001};
    vecs[3]  = '{1'b0, 1'b1, 4'b0000};
    vecs[4]  = '{1'b0, 1'b1, 4'b0111};
    vecs[5]  = '{1'b0, 1'b1, 4'b0111};
    vecs[6]  = '{1'b0, 1'b0, 4'b0010};
    vecs[7]  = '{1'b0, 1'b0, 4'b0010};
    vecs[8]  = '{1'b1, 1'b1, 4'b1001};
    vecs[9]  = '{1'b0, 1'b1, 4'b0000};
    vecs[10] = '{1'b1, 1'b1, 4'b0111};
    vecs[11] = '{1'b1, 1'b0, 4'b0010};
    vecs[12] = '{1'b1, 1'b0, 4'b1001};
    vecs[13] = '{1'b1, 1'b1, 4'b1001};
    vecs[14] = '{1'b0, 1'b0, 4'b0000};
    vecs[15] = '{1'b0, 1'b1, 4'b0111};
    vecs[16] = '{1'b0, 1'b0, 4'b0010};
    vecs[17] = '{1'b0, 1'b0, 4'b0010};

    // Reset held for three cycles, then ten idle cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_a%0d", i), {a_gnt0, a_gnt1, a_sel, a_valid}, 4'b0000);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("idle_a%0d", i), {a_gnt0, a_gnt1, a_sel, a_valid}, 4'b0000);
      check($sformatf("idle_b%0d", i), {b_gnt0, b_gnt1, b_sel, b_valid}, 4'b0000);
      check($sformatf("idle_c%0d", i), {c_gnt0, c_gnt1, c_sel, c_valid}, 4'b0000);
    end

    // Directed vector table on the MAX_HOLD=16 instance.
    for (int i = 0; i < 18; i++) begin
      a_req0 = vecs[i].r0;
      a_req1 = vecs[i].r1;
      step();
      check($sformatf("vec%0d", i), {a_gnt0, a_gnt1, a_sel, a_valid}, vecs[i].exp);
      check_excl($sformatf("excl_a%0d", i), a_gnt0, a_gnt1);
    end
    a_req0 = 1'b0;
    a_req1 = 1'b0;

    // Both requesters held from reset release on the bounded and unbounded instances.
    rst_n  = 1'b0;
    b_req0 = 1'b1; b_req1 = 1'b1;
    c_req0 = 1'b1; c_req1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_valid = 1'b0;
    prev_sel   = 1'b0;
    for (int n = 1; n <= 106; n++) begin
      step();
      p = (n - 1) % 10;
      exp_b[3] = (p < 4);
      exp_b[2] = (p >= 5) && (p < 9);
      exp_b[1] = (p >= 5);
      exp_b[0] = exp_b[3] | exp_b[2];
      check($sformatf("rr_b%0d", n), {b_gnt0, b_gnt1, b_sel, b_valid}, exp_b);
      check_excl($sformatf("excl_b%0d", n), b_gnt0, b_gnt1);
      if (prev_valid && b_valid) begin
        check($sformatf("selstable_b%0d", n), {3'b000, b_sel}, {3'b000, prev_sel});
      end
      prev_valid = b_valid;
      prev_sel   = b_sel;
      check($sformatf("nohold_c%0d", n), {c_gnt0, c_gnt1, c_sel, c_valid}, 4'b1001);
    end

    // Asynchronous reset in the middle of a source-1 grant.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_b", {b_gnt0, b_gnt1, b_sel, b_valid}, 4'b0000);
    check("async_rst_c", {c_gnt0, c_gnt1, c_sel, c_valid}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_b", {b_gnt0, b_gnt1, b_sel, b_valid}, 4'b1001);
    check("post_rst_c", {c_gnt0, c_gnt1, c_sel, c_valid}, 4'b1001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
